bp_me_cce_mem_mux: RTL and testbench
====================================

Name: bp_me_cce_mem_mux

Overview:
- Parametrised N-to-1 memory-side multiplexer for the Memory End.
- Merges the mem_cmd channels of num_cce_p CCEs onto a single memory port using round-robin arbitration.
- Bounds outstanding commands with a credit counter.
- Returns in-order memory responses to the issuing CCE using a source-id FIFO. Takes over from the per-CCE point-to-point memory wiring when CCEs share one memory controller.

Parameters:
- num_cce_p, 4, number of CCE channels (≥1).
- cmd_width_p, 128, width of one mem command packet.
- resp_width_p, 128, width of one mem response packet.
- max_outstanding_p, 4, maximum commands issued but not yet answered (≥1); also the source-id FIFO depth.
- lg_num_cce_lp, localparam, `BSG_SAFE_CLOG2(num_cce_p).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- cce_cmd_i  in  num_cce_p*cmd_width_p  per-CCE command packets.
- cce_cmd_v_i  in  num_cce_p  per-CCE command valid.
- cce_cmd_yumi_o  out  num_cce_p  command consumed (one-hot or zero).
- mem_cmd_o  out  cmd_width_p  selected command.
- mem_cmd_v_o  out  1  command valid to memory.
- mem_cmd_yumi_i  in  1  memory consumed the command.
- mem_resp_i  in  resp_width_p  memory response.
- mem_resp_v_i  in  1  response valid.
- mem_resp_ready_o  out  1  mux can accept the response.
- cce_resp_o  out  resp_width_p  response, broadcast to all CCEs.
- cce_resp_v_o  out  num_cce_p  per-CCE response valid (one-hot or zero).
- cce_resp_ready_i  in  num_cce_p  per-CCE response ready.
- outstanding_o  out  `BSG_SAFE_CLOG2(max_outstanding_p+1)  current outstanding count.

Behaviour:
- Reset values (cycle after reset_i is sampled high):
  - mem_cmd_v_o, cce_cmd_yumi_o, mem_resp_ready_o, cce_resp_v_o all 0; outstanding_o 0.
  - Round-robin pointer at CCE 0; lock cleared; FIFO empty.
  - Reset mid-operation discards all in-flight state. A response arriving after reset is treated as unexpected.
- Issue gating: issue_ok = (outstanding < max_outstanding_p). No same-cycle credit bypass, so a response retiring in the same cycle does not enable issue.
- Arbitration:
  - Combinational round-robin over cce_cmd_v_i, starting at the pointer.
  - mem_cmd_v_o = issue_ok & (any valid | lock).
  - Zero-cycle pass-through: mem_cmd_o = cce_cmd_i[grant].
- Lock state machine (UNLOCKED / LOCKED):
  - UNLOCKED → LOCKED when mem_cmd_v_o=1 and mem_cmd_yumi_i=0. Record the grant.
  - In LOCKED, the grant is frozen and the recorded CCE's valid is held by the protocol.
  - LOCKED → UNLOCKED on mem_cmd_yumi_i.
- On mem_cmd_yumi_i:
  - cce_cmd_yumi_o[grant]=1 in the same cycle.
  - Push grant to the source-id FIFO; outstanding +1.
  - Pointer ← grant+1, wrapping num_cce_p-1 → 0.
  - mem_cmd_yumi_i is only legal while mem_cmd_v_o=1.
- Responses (in order, zero latency):
  - head = FIFO head.
  - cce_resp_v_o[head] = mem_resp_v_i & ~fifo_empty.
  - mem_resp_ready_o = ~fifo_empty & cce_resp_ready_i[head].
  - On handshake, pop the FIFO; outstanding -1.
- Same-cycle events:
  - Issue and retire in the same cycle leave outstanding unchanged.
  - FIFO push and pop in the same cycle are both legal at any occupancy, because the count is below max whenever a push occurs.
- Unexpected response (mem_resp_v_i with the FIFO empty): ready stays 0 and the response is held back.
- Counters never wrap; simulation asserts on overflow or underflow.

Optional Feature:
- Macro BP_ME_CCE_MEM_MUX_PERF_EN.
- Defined:
  - Adds output stall_cnt_o [31:0]: cycles with any cce_cmd_v_i=1 and issue_ok=0.
  - Adds output issue_cnt_o [31:0]: number of mem_cmd_yumi_i handshakes.
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Reset, then CCE2 valid and memory yumis immediately → same cycle: mem_cmd_o=CCE2 packet, cce_cmd_yumi_o=4'b0100; outstanding_o=1 next cycle; pointer=3.
- All four CCEs valid continuously, yumi every cycle, max_outstanding_p=8 → grants 0,1,2,3,0 on successive cycles, no starvation.
- With max_outstanding_p=4, issue 4 commands and withhold responses → mem_cmd_v_o=0 and outstanding_o=4 while any CCE is valid. One response retires → mem_cmd_v_o=1 on the following cycle.
- CCE1 presents, memory withholds yumi for 3 cycles while CCE0 raises valid → mem_cmd_o stays the CCE1 packet (lock). On yumi, cce_cmd_yumi_o=4'b0010; CCE0 is granted next.
- Issue order CCE3, CCE0, CCE3; three responses A, B, C → cce_resp_v_o = 4'b1000, 4'b0001, 4'b1000 in order. Dropping cce_resp_ready_i[0] during B → mem_resp_ready_o=0 and B holds until ready returns.
- Response with outstanding_o=0 → mem_resp_ready_o=0 and cce_resp_v_o=0. Assert reset_i with 3 outstanding → outstanding_o=0 and FIFO empty the next cycle.

Source files
------------

// File: rtl/bp_me_cce_mem_mux.sv
// N-to-1 memory-side mux: round-robin command arbitration with a lock on stalled grants,
// a credit-bounded source-id FIFO for in-order response return. Optional perf counters: BP_ME_CCE_MEM_MUX_PERF_EN.
module bp_me_cce_mem_mux #(
    parameter int unsigned num_cce_p         = 4,
    parameter int unsigned cmd_width_p       = 128,
    parameter int unsigned resp_width_p      = 128,
    parameter int unsigned max_outstanding_p = 4,
    localparam int unsigned lg_num_cce_lp    = (num_cce_p > 1) ? $clog2(num_cce_p) : 1,
    localparam int unsigned cnt_width_lp     = ((max_outstanding_p + 1) > 1) ? $clog2(max_outstanding_p + 1) : 1,
    localparam int unsigned ptr_width_lp     = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_cce_p*cmd_width_p-1:0] cce_cmd_i,
    input  logic [num_cce_p-1:0]             cce_cmd_v_i,
    output logic [num_cce_p-1:0]             cce_cmd_yumi_o,
    output logic [cmd_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_yumi_i,
    input  logic [resp_width_p-1:0]          mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_ready_o,
    output logic [resp_width_p-1:0]          cce_resp_o,
    output logic [num_cce_p-1:0]             cce_resp_v_o,
    input  logic [num_cce_p-1:0]             cce_resp_ready_i,
`ifdef BP_ME_CCE_MEM_MUX_PERF_EN
    output logic [31:0]                      stall_cnt_o,
    output logic [31:0]                      issue_cnt_o,
`endif
    output logic [cnt_width_lp-1:0]          outstanding_o
);

    typedef enum logic {
        e_unlocked,
        e_locked
    } lock_state_e;

    lock_state_e              state_r, state_n;
    logic [lg_num_cce_lp-1:0] rr_ptr_r, rr_ptr_n;
    logic [lg_num_cce_lp-1:0] lock_gnt_r, lock_gnt_n;
    logic [lg_num_cce_lp-1:0] rr_gnt, gnt, head;
    logic [cnt_width_lp-1:0]  out_r;
    logic [ptr_width_lp-1:0]  wr_ptr_r, rd_ptr_r;
    logic [lg_num_cce_lp-1:0] fifo_mem [max_outstanding_p];
    logic                     any_v, issue_ok, cmd_hs, resp_hs, fifo_empty;

    // First valid requester at or after the pointer, wrapping.
    function automatic logic [lg_num_cce_lp-1:0] rr_pick(
        input logic [num_cce_p-1:0]     v,
        input logic [lg_num_cce_lp-1:0] p
    );
        logic                     found;
        logic [lg_num_cce_lp-1:0] idx;
        rr_pick = p;
        found   = 1'b0;
        for (int unsigned i = 0; i < num_cce_p; i++) begin
            idx = lg_num_cce_lp'((32'(p) + i) % num_cce_p);
            if (!found && v[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        ptr_inc = (p == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Command path: credit gating, grant selection and pass-through.
    always_comb begin
        any_v          = |cce_cmd_v_i;
        issue_ok       = out_r < cnt_width_lp'(max_outstanding_p);
        rr_gnt         = rr_pick(cce_cmd_v_i, rr_ptr_r);
        gnt            = (state_r == e_locked) ? lock_gnt_r : rr_gnt;
        mem_cmd_v_o    = issue_ok & (any_v | (state_r == e_locked));
        mem_cmd_o      = cce_cmd_i[32'(gnt)*cmd_width_p +: cmd_width_p];
        cmd_hs         = mem_cmd_v_o & mem_cmd_yumi_i;
        cce_cmd_yumi_o = cmd_hs ? (num_cce_p'(1) << gnt) : '0;
    end

    // Lock FSM next state and round-robin pointer update.
    always_comb begin
        state_n    = state_r;
        lock_gnt_n = lock_gnt_r;
        rr_ptr_n   = rr_ptr_r;
        case (state_r)
            e_unlocked: begin
                if (mem_cmd_v_o && !mem_cmd_yumi_i) begin
                    state_n    = e_locked;
                    lock_gnt_n = gnt;
                end
            end
            e_locked: begin
                if (mem_cmd_yumi_i) state_n = e_unlocked;
            end
            default: state_n = e_unlocked;
        endcase
        if (cmd_hs) begin
            rr_ptr_n = (gnt == lg_num_cce_lp'(num_cce_p - 1)) ? '0 : gnt + 1'b1;
        end
    end

    // Response path: the FIFO head names the CCE that owns the next response.
    always_comb begin
        fifo_empty       = (out_r == '0);
        head             = fifo_mem[rd_ptr_r];
        mem_resp_ready_o = ~fifo_empty & cce_resp_ready_i[head];
        cce_resp_v_o     = (mem_resp_v_i & ~fifo_empty) ? (num_cce_p'(1) << head) : '0;
        resp_hs          = mem_resp_v_i & mem_resp_ready_o;
        cce_resp_o       = mem_resp_i;
        outstanding_o    = out_r;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_unlocked;
            lock_gnt_r <= '0;
            rr_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            out_r      <= '0;
        end else begin
            state_r    <= state_n;
            lock_gnt_r <= lock_gnt_n;
            rr_ptr_r   <= rr_ptr_n;
            if (cmd_hs)  wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (resp_hs) rd_ptr_r <= ptr_inc(rd_ptr_r);
            out_r <= out_r + cnt_width_lp'(cmd_hs) - cnt_width_lp'(resp_hs);
            assert (!(cmd_hs && !resp_hs && out_r == cnt_width_lp'(max_outstanding_p)));
            assert (!(resp_hs && !cmd_hs && out_r == '0));
            assert (!(mem_cmd_yumi_i && !mem_cmd_v_o));
        end
    end

    // Payload storage carries no reset; occupancy is tracked by out_r.
    always_ff @(posedge clk_i) begin
        if (cmd_hs) fifo_mem[wr_ptr_r] <= gnt;
    end

`ifdef BP_ME_CCE_MEM_MUX_PERF_EN
    // Saturating stall and issue counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_o <= '0;
            issue_cnt_o <= '0;
        end else begin
            if (any_v && !issue_ok && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (cmd_hs && issue_cnt_o != 32'hFFFF_FFFF) issue_cnt_o <= issue_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_me_cce_mem_mux.sv
// Directed bench for bp_me_cce_mem_mux: arbitration, credit limit, lock, in-order return and reset.
module tb_bp_me_cce_mem_mux;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned RW = 32;
    localparam int unsigned MO = 4;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [N*CW-1:0] cce_cmd_i;
    logic [N-1:0]    cce_cmd_v_i;
    logic [N-1:0]    cce_cmd_yumi_o;
    logic [CW-1:0]   mem_cmd_o;
    logic            mem_cmd_v_o;
    logic            mem_cmd_yumi_i;
    logic [RW-1:0]   mem_resp_i;
    logic            mem_resp_v_i;
    logic            mem_resp_ready_o;
    logic [RW-1:0]   cce_resp_o;
    logic [N-1:0]    cce_resp_v_o;
    logic [N-1:0]    cce_resp_ready_i;
    logic [2:0]      outstanding_o;
`ifdef BP_ME_CCE_MEM_MUX_PERF_EN
    logic [31:0]     stall_cnt_o;
    logic [31:0]     issue_cnt_o;
`endif

    bp_me_cce_mem_mux #(
        .num_cce_p(N), .cmd_width_p(CW), .resp_width_p(RW), .max_outstanding_p(MO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cce_cmd_i(cce_cmd_i), .cce_cmd_v_i(cce_cmd_v_i), .cce_cmd_yumi_o(cce_cmd_yumi_o),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
        .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
        .cce_resp_o(cce_resp_o), .cce_resp_v_o(cce_resp_v_o), .cce_resp_ready_i(cce_resp_ready_i),
`ifdef BP_ME_CCE_MEM_MUX_PERF_EN
        .stall_cnt_o(stall_cnt_o), .issue_cnt_o(issue_cnt_o),
`endif
        .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_err = 0;
    int          out_m = 0;
    logic [3:0]  sb[$];
    logic [31:0] resp_data = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pkt(input logic [3:0] oh);
        logic [31:0] r;
        r = 32'hC0DE_0000;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 32'hC0DE_0000 | 32'(i);
        return r;
    endfunction

    // One clock of stimulus; expected command grant and response owner come from the bench model.
    task automatic drive_cycle(input logic [3:0] v, input logic yumi, input logic [3:0] gnt,
                               input logic exp_v, input logic rv, input logic [3:0] rdy);
        logic [3:0] head;
        logic       exp_rdy;
        cce_cmd_v_i      = v;
        mem_cmd_yumi_i   = yumi;
        mem_resp_v_i     = rv;
        cce_resp_ready_i = rdy;
        mem_resp_i       = resp_data;
        #1;
        check("cmd_v", 64'(mem_cmd_v_o), 64'(exp_v));
        if (exp_v) check("cmd_data", 64'(mem_cmd_o), 64'(pkt(gnt)));
        check("cmd_yumi", 64'(cce_cmd_yumi_o), (yumi && exp_v) ? 64'(gnt) : 64'd0);
        head    = (sb.size() > 0) ? sb[0] : 4'b0000;
        exp_rdy = |(head & rdy);
        check("resp_v", 64'(cce_resp_v_o), rv ? 64'(head) : 64'd0);
        check("resp_ready", 64'(mem_resp_ready_o), 64'(exp_rdy));
        if (rv) check("resp_data", 64'(cce_resp_o), 64'(resp_data));
        if (rv && exp_rdy) begin
            sb.delete(0);
            out_m--;
        end
        if (yumi) begin
            sb.push_back(gnt);
            out_m++;
        end
        @(posedge clk_i);
        #1;
        check("outstanding", 64'(outstanding_o), 64'(out_m));
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) cce_cmd_i[i*CW +: CW] = 32'hC0DE_0000 | 32'(i);
        reset_i = 1'b1;
        cce_cmd_v_i = '0; mem_cmd_yumi_i = 1'b0; mem_resp_v_i = 1'b0;
        cce_resp_ready_i = '0; mem_resp_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        #1;
        check("rst_cmd_v", 64'(mem_cmd_v_o), 64'd0);
        check("rst_cmd_yumi", 64'(cce_cmd_yumi_o), 64'd0);
        check("rst_resp_ready", 64'(mem_resp_ready_o), 64'd0);
        check("rst_resp_v", 64'(cce_resp_v_o), 64'd0);
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Single CCE2 issue; pointer moves to 3
        drive_cycle(4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000);

        // All valid, yumi every cycle, one response retiring per cycle: 3,0,1,2,3
        drive_cycle(4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 4'b1111);
        drive_cycle(4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b1111);
        drive_cycle(4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b1111);
        drive_cycle(4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b1111);
        drive_cycle(4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 4'b1111);
        drive_cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);

        // Credit limit: fill, stall, retire one (no bypass), issue again, drain
        drive_cycle(4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        drive_cycle(4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);
        drive_cycle(4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000);
        repeat (4) drive_cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);

        // Move pointer to 2, then lock on CCE1 while CCE0 also requests
        drive_cycle(4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000);
        repeat (3) drive_cycle(4'b0011, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b0011, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000);
        repeat (3) drive_cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);

        // In-order return to CCE3, CCE0, CCE3 with back-pressure on B
        drive_cycle(4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000);
        resp_data = 32'hAAAA_0001;
        drive_cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);
        resp_data = 32'hBBBB_0002;
        drive_cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1110);
        drive_cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1110);
        drive_cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);
        resp_data = 32'hCCCC_0003;
        drive_cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);

        // Unexpected response with nothing outstanding
        resp_data = 32'hDEAD_0004;
        drive_cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);

        // Reset with three outstanding and a live lock on CCE3
        drive_cycle(4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000);
        cce_cmd_v_i = '0; mem_cmd_yumi_i = 1'b0; mem_resp_v_i = 1'b0;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        sb.delete();
        out_m = 0;
        #1;
        check("mid_rst_outstanding", 64'(outstanding_o), 64'd0);
        check("mid_rst_cmd_v", 64'(mem_cmd_v_o), 64'd0);
        @(posedge clk_i);
        #1;
        drive_cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);
        drive_cycle(4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000);
        drive_cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
